rp_8bit_fetch: RTL and testbench
================================

# rp_8bit_fetch

Instruction fetch sequencer for the rp_8bit core. It reads 16-bit words from program memory over a request/acknowledge port and assembles 1- or 2-word AVR instructions (lds, sts, jmp, call take two words). It presents each instruction with its word address to the decoder through a valid/ready handshake. It also handles redirects for jumps, branches, calls and returns, and skips for cpse, sbrc, sbrs, sbic and sbis.

## Interface
- `PAW`, 11 – program address width in 16-bit words.
- `clk` input, 1 – clock, all state on rising edge.
- `rst` input, 1 – asynchronous active-high reset.
- `pmem_req` output, 1 – program memory read request; held until acknowledged.
- `pmem_adr` output, PAW – word address; stable while `pmem_req` is high.
- `pmem_ack` input, 1 – request accepted; `pmem_rdt` valid in this same cycle.
- `pmem_rdt` input, 16 – read data.
- `ins_vld` output, 1 – instruction valid.
- `ins_rdy` input, 1 – decoder accepts the instruction.
- `ins_code` output, 32 – [15:0] is the first word, [31:16] is the second word (zero for 1-word instructions).
- `ins_len` output, 1 – 0 means 1 word, 1 means 2 words.
- `ins_pc` output, PAW – word address of the first word.
- `jmp_vld` input, 1 – redirect request.
- `jmp_adr` input, PAW – redirect target (word address).
- `skp_vld` input, 1 – skip the next instruction; qualified only in a cycle with `ins_vld && ins_rdy`.

## Operation
- FSM states:
  - WRD1 – fetching the first word.
  - WRD2 – fetching the second word.
  - OUT – holding the instruction for the decoder.
  - Reset state is WRD1 with `pc` = 0.
- WRD1:
  - `pmem_req` = 1, `pmem_adr` = `pc`.
  - On `pmem_ack`: `pc` ← `pc`+1, first word latched.
  - If the word is a 2-word opcode, go to WRD2; else go to OUT.
- 2-word opcode detection (package function `is_2word`): `1001_00??_????_0000` (lds/sts) or `1001_010?_????_11??` (jmp/call).
- WRD2:
  - `pmem_req` = 1, `pmem_adr` = `pc`.
  - On `pmem_ack`: `pc` ← `pc`+1, second word latched, go to OUT.
- OUT:
  - `ins_vld` = 1. `ins_code`, `ins_len` and `ins_pc` are stable until the handshake.
  - On handshake, go to WRD1. No prefetch while in OUT.
- Skip:
  - `skp_vld` high during a handshake sets the `skip` flag.
  - The next instruction is fetched completely (1 or 2 words, using `is_2word`). It then goes straight to WRD1 without entering OUT, and `skip` clears.
  - `ins_vld` never rises for a skipped instruction.
- Redirect (`jmp_vld`), from any state:
  - Next cycle: state is WRD1, `pc` = `jmp_adr`, `skip` cleared, `ins_vld` = 0.
  - Words acknowledged in the same cycle as `jmp_vld` are discarded.
  - A `pmem_req` that has not been acknowledged is dropped in the cycle after `jmp_vld`. Memory must tolerate an abandoned request.
- Priority:
  - `jmp_vld` beats `skp_vld`, which beats a normal fetch.
  - A handshake coinciding with `jmp_vld` still counts as consumed. The redirect wins the next fetch.
- `pc` increments modulo 2^PAW. Address 2^PAW−1 followed by 0 is legal, including for the second word of a 2-word instruction.

## Timing
- Reset values: `pmem_req` = 1 (first cycle after reset release, combinational from state), `pmem_adr` = 0, `ins_vld` = 0, `ins_code` = 0, `ins_len` = 0, `ins_pc` = 0, `skip` = 0.
- Outputs are driven from registers or state only. `pmem_req` and `pmem_adr` are not combinationally dependent on `pmem_ack`, `ins_rdy` or `jmp_vld`.
- Latency: `ins_vld` rises the cycle after the last word's `pmem_ack`.
- Throughput with a zero-wait memory (ack in the request cycle):
  - 1-word instruction: 2 cycles.
  - 2-word instruction: 3 cycles.
  - Skipped instruction: 1 or 2 extra cycles.
- Reset asserted mid-operation aborts immediately. Everything returns to reset values asynchronously.

## Structure
- Package `rp_8bit_pkg` holds:
  - `function is_2word(logic [15:0])`.
  - The FSM enum `fetch_st_t` {WRD1, WRD2, OUT}.
- Single flat module; no sub-module needed.

## Test plan
- Reset, then a memory returning `0x0000` (nop) with zero-wait ack → `pmem_adr` 0, 1, 2 and so on. `ins_pc` is 0, 1, 2 with `ins_len` = 0, and `ins_vld` is high every second cycle.
- Word 0 = `0x9100` (lds r16), word 1 = `0x0123` → a single `ins_vld` with `ins_code` = `0x0123_9100`, `ins_len` = 1, `ins_pc` = 0. The next `ins_pc` is 2.
- `skp_vld` during the handshake at pc 0, where words 1–2 are `0x940C`/`0x0040` (jmp) → no `ins_vld` for pc 1. The next delivered `ins_pc` is 3.
- `ins_rdy` held low for 5 cycles → `ins_code` and `ins_pc` stay stable, and `pmem_req` stays 0 throughout.
- `jmp_vld` with `jmp_adr` = `0x155` while in WRD2 with ack pending → the partial instruction is never delivered. The next `pmem_adr` is `0x155` and `skip` is cleared.
- `PAW` = 4, `jmp_adr` = 15, with a 2-word instruction at 15 → the second word is fetched from address 0, and the next `ins_pc` is 1.

Source files
------------

// File: rtl/rp_8bit_pkg.sv
// rp_8bit_pkg: shared types and helpers for the rp_8bit core.
//   fetch_st_t : instruction fetch FSM state encoding
//   is_2word() : flags first words of 2-word AVR opcodes (lds, sts, jmp, call)
package rp_8bit_pkg;

  typedef enum logic [1:0] {
    WRD1 = 2'd0,
    WRD2 = 2'd1,
    OUT  = 2'd2
  } fetch_st_t;

  // lds/sts: 1001_00??_????_0000, jmp/call: 1001_010?_????_11??
  function automatic logic is_2word(input logic [15:0] w);
    return ((w[15:10] == 6'b100100) && (w[3:0] == 4'b0000)) ||
           ((w[15:9] == 7'b1001010) && (w[3:2] == 2'b11));
  endfunction

endpackage

// File: rtl/rp_8bit_fetch.sv
// rp_8bit_fetch: instruction fetch sequencer for the rp_8bit core.
// Reads 16-bit words from program memory, assembles 1- or 2-word
// instructions and hands them to the decoder over valid/ready. Handles
// redirects (jmp_vld) and skips (skp_vld during a decoder handshake).
//
// Ports:
//   clk, rst            clock, async active-high reset
//   pmem_req/adr        program memory request and word address (out)
//   pmem_ack/rdt        memory accept and same-cycle read data (in)
//   ins_vld/rdy         instruction handshake to the decoder
//   ins_code/len/pc     instruction words, length (0=1w, 1=2w), word address
//   jmp_vld/adr         redirect request and target
//   skp_vld             skip the next instruction (qualified by handshake)
//
// state | meaning
// ------+-------------------------------------------------
// WRD1  | fetching the first word of an instruction
// WRD2  | fetching the second word of a 2-word instruction
// OUT   | holding the instruction for the decoder
module rp_8bit_fetch
  import rp_8bit_pkg::*;
#(
  parameter int PAW = 11
) (
  input  logic           clk,
  input  logic           rst,
  output logic           pmem_req,
  output logic [PAW-1:0] pmem_adr,
  input  logic           pmem_ack,
  input  logic [15:0]    pmem_rdt,
  output logic           ins_vld,
  input  logic           ins_rdy,
  output logic [31:0]    ins_code,
  output logic           ins_len,
  output logic [PAW-1:0] ins_pc,
  input  logic           jmp_vld,
  input  logic [PAW-1:0] jmp_adr,
  input  logic           skp_vld
);

  fetch_st_t      st, st_nxt;
  logic [PAW-1:0] pc, pc_nxt;
  logic [PAW-1:0] ipc, ipc_nxt;
  logic [31:0]    code, code_nxt;
  logic           len, len_nxt;
  logic           skip, skip_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= WRD1;
      pc   <= '0;
      ipc  <= '0;
      code <= '0;
      len  <= 1'b0;
      skip <= 1'b0;
    end else begin
      st   <= st_nxt;
      pc   <= pc_nxt;
      ipc  <= ipc_nxt;
      code <= code_nxt;
      len  <= len_nxt;
      skip <= skip_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    pc_nxt   = pc;
    ipc_nxt  = ipc;
    code_nxt = code;
    len_nxt  = len;
    skip_nxt = skip;
    if (jmp_vld) begin
      // Redirect wins over everything; any word acked this cycle is dropped.
      st_nxt   = WRD1;
      pc_nxt   = jmp_adr;
      skip_nxt = 1'b0;
    end else begin
      case (st)
        WRD1: begin
          if (pmem_ack) begin
            pc_nxt   = pc + 1'b1;
            ipc_nxt  = pc;
            code_nxt = {16'h0000, pmem_rdt};
            len_nxt  = is_2word(pmem_rdt);
            if (is_2word(pmem_rdt)) begin
              st_nxt = WRD2;
            end else if (skip) begin
              // Skipped 1-word instruction: fetch the next one directly.
              st_nxt   = WRD1;
              skip_nxt = 1'b0;
            end else begin
              st_nxt = OUT;
            end
          end
        end
        WRD2: begin
          if (pmem_ack) begin
            pc_nxt   = pc + 1'b1;
            code_nxt = {pmem_rdt, code[15:0]};
            if (skip) begin
              st_nxt   = WRD1;
              skip_nxt = 1'b0;
            end else begin
              st_nxt = OUT;
            end
          end
        end
        OUT: begin
          if (ins_rdy) begin
            st_nxt   = WRD1;
            skip_nxt = skp_vld;
          end
        end
        default: st_nxt = WRD1;
      endcase
    end
  end

  assign pmem_req = (st != OUT);
  assign pmem_adr = pc;
  assign ins_vld  = (st == OUT);
  assign ins_code = code;
  assign ins_len  = len;
  assign ins_pc   = ipc;

endmodule

// File: tb/tb_rp_8bit_fetch.sv
module tb_rp_8bit_fetch;

  logic        clk;
  logic        rst;

  // PAW = 11 instance
  logic        pmem_req;
  logic [10:0] pmem_adr;
  logic        pmem_ack;
  logic [15:0] pmem_rdt;
  logic        ins_vld;
  logic        ins_rdy;
  logic [31:0] ins_code;
  logic        ins_len;
  logic [10:0] ins_pc;
  logic        jmp_vld;
  logic [10:0] jmp_adr;
  logic        skp_vld;
  logic        ack_en;
  logic [15:0] mem [64];

  // PAW = 4 instance
  logic        pmem_req4;
  logic [3:0]  pmem_adr4;
  logic        pmem_ack4;
  logic [15:0] pmem_rdt4;
  logic        ins_vld4;
  logic [31:0] ins_code4;
  logic        ins_len4;
  logic [3:0]  ins_pc4;
  logic        jmp_vld4;
  logic [3:0]  jmp_adr4;
  logic [15:0] mem4 [16];

  int checks;
  int errors;

  rp_8bit_fetch #(.PAW(11)) u_dut (
    .clk(clk), .rst(rst),
    .pmem_req(pmem_req), .pmem_adr(pmem_adr), .pmem_ack(pmem_ack), .pmem_rdt(pmem_rdt),
    .ins_vld(ins_vld), .ins_rdy(ins_rdy), .ins_code(ins_code), .ins_len(ins_len),
    .ins_pc(ins_pc), .jmp_vld(jmp_vld), .jmp_adr(jmp_adr), .skp_vld(skp_vld)
  );

  rp_8bit_fetch #(.PAW(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .pmem_req(pmem_req4), .pmem_adr(pmem_adr4), .pmem_ack(pmem_ack4), .pmem_rdt(pmem_rdt4),
    .ins_vld(ins_vld4), .ins_rdy(1'b1), .ins_code(ins_code4), .ins_len(ins_len4),
    .ins_pc(ins_pc4), .jmp_vld(jmp_vld4), .jmp_adr(jmp_adr4), .skp_vld(1'b0)
  );

  // Zero-wait memory models (ack in the request cycle)
  assign pmem_ack  = pmem_req & ack_en;
  assign pmem_rdt  = mem[pmem_adr[5:0]];
  assign pmem_ack4 = pmem_req4;
  assign pmem_rdt4 = mem4[pmem_adr4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++; if (pmem_req !== 1'b1) begin errors++; $display("FAIL rst_req got %b exp 1", pmem_req); end
    checks++; if (pmem_adr !== 11'd0) begin errors++; $display("FAIL rst_adr got %h exp 000", pmem_adr); end
    checks++; if (ins_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", ins_vld); end
    checks++; if (ins_code !== 32'h0) begin errors++; $display("FAIL rst_code got %h exp 00000000", ins_code); end
    checks++; if (ins_len !== 1'b0) begin errors++; $display("FAIL rst_len got %b exp 0", ins_len); end
    checks++; if (ins_pc !== 11'd0) begin errors++; $display("FAIL rst_pc got %h exp 000", ins_pc); end
    rst = 1'b0;
  endtask

  task automatic test_nop_stream();
    clear_mem();
    ins_rdy = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++; if (pmem_req !== 1'b1 || pmem_adr !== 11'(i) || ins_vld !== 1'b0) begin
        errors++; $display("FAIL nop_fetch%0d req %b adr %h vld %b exp 1 %h 0", i, pmem_req, pmem_adr, ins_vld, 11'(i));
      end
      step();
      checks++; if (ins_vld !== 1'b1 || ins_pc !== 11'(i) || ins_len !== 1'b0 || pmem_req !== 1'b0) begin
        errors++; $display("FAIL nop_out%0d vld %b pc %h len %b req %b exp 1 %h 0 0", i, ins_vld, ins_pc, ins_len, pmem_req, 11'(i));
      end
      step();
    end
  endtask

  task automatic test_two_word();
    clear_mem();
    mem[0] = 16'h9100;
    mem[1] = 16'h0123;
    ins_rdy = 1'b1;
    do_reset();
    step();
    checks++; if (pmem_adr !== 11'd1 || pmem_req !== 1'b1 || ins_vld !== 1'b0) begin
      errors++; $display("FAIL lds_wrd2 adr %h req %b vld %b exp 001 1 0", pmem_adr, pmem_req, ins_vld);
    end
    step();
    checks++; if (ins_vld !== 1'b1 || ins_code !== 32'h0123_9100 || ins_len !== 1'b1 || ins_pc !== 11'd0) begin
      errors++; $display("FAIL lds_out vld %b code %h len %b pc %h exp 1 01239100 1 000", ins_vld, ins_code, ins_len, ins_pc);
    end
    step();
    checks++; if (pmem_adr !== 11'd2 || ins_vld !== 1'b0) begin
      errors++; $display("FAIL lds_next_adr adr %h vld %b exp 002 0", pmem_adr, ins_vld);
    end
    step();
    checks++; if (ins_vld !== 1'b1 || ins_pc !== 11'd2 || ins_len !== 1'b0 || ins_code !== 32'h0) begin
      errors++; $display("FAIL lds_next_out vld %b pc %h len %b code %h exp 1 002 0 00000000", ins_vld, ins_pc, ins_len, ins_code);
    end
  endtask

  task automatic test_skip();
    clear_mem();
    mem[1] = 16'h940C;
    mem[2] = 16'h0040;
    ins_rdy = 1'b1;
    do_reset();
    step();
    checks++; if (ins_vld !== 1'b1 || ins_pc !== 11'd0) begin
      errors++; $display("FAIL skp_first vld %b pc %h exp 1 000", ins_vld, ins_pc);
    end
    skp_vld = 1'b1;
    step();
    skp_vld = 1'b0;
    checks++; if (pmem_adr !== 11'd1 || ins_vld !== 1'b0) begin
      errors++; $display("FAIL skp_w1 adr %h vld %b exp 001 0", pmem_adr, ins_vld);
    end
    step();
    checks++; if (pmem_adr !== 11'd2 || ins_vld !== 1'b0) begin
      errors++; $display("FAIL skp_w2 adr %h vld %b exp 002 0", pmem_adr, ins_vld);
    end
    step();
    checks++; if (pmem_adr !== 11'd3 || ins_vld !== 1'b0 || pmem_req !== 1'b1) begin
      errors++; $display("FAIL skp_after adr %h vld %b req %b exp 003 0 1", pmem_adr, ins_vld, pmem_req);
    end
    step();
    checks++; if (ins_vld !== 1'b1 || ins_pc !== 11'd3) begin
      errors++; $display("FAIL skp_next vld %b pc %h exp 1 003", ins_vld, ins_pc);
    end
    // skip a 1-word instruction at pc 4
    skp_vld = 1'b1;
    step();
    skp_vld = 1'b0;
    checks++; if (pmem_adr !== 11'd4 || ins_vld !== 1'b0) begin
      errors++; $display("FAIL skp1_w adr %h vld %b exp 004 0", pmem_adr, ins_vld);
    end
    step();
    checks++; if (pmem_adr !== 11'd5 || ins_vld !== 1'b0) begin
      errors++; $display("FAIL skp1_after adr %h vld %b exp 005 0", pmem_adr, ins_vld);
    end
    step();
    checks++; if (ins_vld !== 1'b1 || ins_pc !== 11'd5) begin
      errors++; $display("FAIL skp1_next vld %b pc %h exp 1 005", ins_vld, ins_pc);
    end
  endtask

  task automatic test_stall();
    clear_mem();
    mem[0] = 16'h1234;
    ins_rdy = 1'b0;
    do_reset();
    step();
    for (int i = 0; i < 5; i++) begin
      checks++; if (ins_vld !== 1'b1 || ins_pc !== 11'd0 || ins_code !== 32'h0000_1234 || pmem_req !== 1'b0) begin
        errors++; $display("FAIL stall%0d vld %b pc %h code %h req %b exp 1 000 00001234 0", i, ins_vld, ins_pc, ins_code, pmem_req);
      end
      step();
    end
    ins_rdy = 1'b1;
    step();
    checks++; if (pmem_req !== 1'b1 || pmem_adr !== 11'd1 || ins_vld !== 1'b0) begin
      errors++; $display("FAIL stall_release req %b adr %h vld %b exp 1 001 0", pmem_req, pmem_adr, ins_vld);
    end
  endtask

  task automatic test_jump();
    clear_mem();
    mem[1] = 16'h9100;
    mem[2] = 16'h0123;
    ins_rdy = 1'b1;
    do_reset();
    step();
    skp_vld = 1'b1;           // handshake at pc 0 arms skip
    step();
    skp_vld = 1'b0;
    step();                   // WRD2 at address 2 now
    ack_en  = 1'b0;
    jmp_vld = 1'b1;
    jmp_adr = 11'h155;
    checks++; if (pmem_adr !== 11'd2 || pmem_req !== 1'b1) begin
      errors++; $display("FAIL jmp_pending adr %h req %b exp 002 1", pmem_adr, pmem_req);
    end
    step();
    jmp_vld = 1'b0;
    ack_en  = 1'b1;
    checks++; if (pmem_adr !== 11'h155 || pmem_req !== 1'b1 || ins_vld !== 1'b0) begin
      errors++; $display("FAIL jmp_target adr %h req %b vld %b exp 155 1 0", pmem_adr, pmem_req, ins_vld);
    end
    step();
    // skip was cleared by the redirect, so the target is delivered
    checks++; if (ins_vld !== 1'b1 || ins_pc !== 11'h155 || ins_len !== 1'b0) begin
      errors++; $display("FAIL jmp_deliver vld %b pc %h len %b exp 1 155 0", ins_vld, ins_pc, ins_len);
    end
    step();
    // redirect in the same cycle as an ack drops that word
    jmp_vld = 1'b1;
    jmp_adr = 11'h010;
    step();
    jmp_vld = 1'b0;
    checks++; if (pmem_adr !== 11'h010 || ins_vld !== 1'b0 || pmem_req !== 1'b1) begin
      errors++; $display("FAIL jmp_ack_drop adr %h vld %b req %b exp 010 0 1", pmem_adr, ins_vld, pmem_req);
    end
    step();
    checks++; if (ins_vld !== 1'b1 || ins_pc !== 11'h010) begin
      errors++; $display("FAIL jmp_ack_next vld %b pc %h exp 1 010", ins_vld, ins_pc);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) mem4[i] = 16'h0000;
    mem4[15] = 16'h940C;
    mem4[0]  = 16'h0040;
    do_reset();
    jmp_vld4 = 1'b1;
    jmp_adr4 = 4'd15;
    step();
    jmp_vld4 = 1'b0;
    checks++; if (pmem_adr4 !== 4'd15 || ins_vld4 !== 1'b0) begin
      errors++; $display("FAIL wrap_w1 adr %h vld %b exp f 0", pmem_adr4, ins_vld4);
    end
    step();
    checks++; if (pmem_adr4 !== 4'd0 || pmem_req4 !== 1'b1) begin
      errors++; $display("FAIL wrap_w2 adr %h req %b exp 0 1", pmem_adr4, pmem_req4);
    end
    step();
    checks++; if (ins_vld4 !== 1'b1 || ins_code4 !== 32'h0040_940C || ins_len4 !== 1'b1 || ins_pc4 !== 4'd15) begin
      errors++; $display("FAIL wrap_out vld %b code %h len %b pc %h exp 1 0040940c 1 f", ins_vld4, ins_code4, ins_len4, ins_pc4);
    end
    step();
    checks++; if (pmem_adr4 !== 4'd1) begin
      errors++; $display("FAIL wrap_next_adr adr %h exp 1", pmem_adr4);
    end
    step();
    checks++; if (ins_vld4 !== 1'b1 || ins_pc4 !== 4'd1) begin
      errors++; $display("FAIL wrap_next_out vld %b pc %h exp 1 1", ins_vld4, ins_pc4);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    ins_rdy  = 1'b0;
    jmp_vld  = 1'b0;
    jmp_adr  = '0;
    skp_vld  = 1'b0;
    ack_en   = 1'b1;
    jmp_vld4 = 1'b0;
    jmp_adr4 = '0;
    clear_mem();
    for (int i = 0; i < 16; i++) mem4[i] = 16'h0000;
    test_reset();
    test_nop_stream();
    test_two_word();
    test_skip();
    test_stall();
    test_jump();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
